// File: rtl/seq_div_if.sv
// Start/busy/done handshake bundle for the sequential signed divider.
interface seq_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Iterative signed restoring divider: one quotient bit per clock,
// truncating toward zero, with start/busy/done handshake.
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz_pend;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Magnitudes as unsigned WIDTH bits; the most negative value maps exactly.
  assign w_a_mag  = bus.A[WIDTH-1] ? WIDTH'(-bus.A) : bus.A;
  assign w_b_mag  = bus.B[WIDTH-1] ? WIDTH'(-bus.B) : bus.B;
  assign w_b_zero = (bus.B == '0);

  // Partial remainder is widened by one bit so the subtract borrow is the compare.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_a        <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A request arriving in the done cycle is dropped.
          if (bus.start && !r_done) begin
            r_dvd      <= w_a_mag;
            r_dvs      <= w_b_mag;
            r_a        <= bus.A;
            r_sign_q   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            r_sign_r   <= bus.A[WIDTH-1];
            r_dbz_pend <= w_b_zero;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= w_b_zero ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_dbz  <= r_dbz_pend;
          if (r_dbz_pend) begin
            r_q <= '1;
            r_r <= r_a;
          end else begin
            r_q <= r_sign_q ? WIDTH'(-r_dvd) : r_dvd;
            r_r <= r_sign_r ? WIDTH'(-r_rem) : r_rem;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: random and directed divides against a
// longint arithmetic reference, with latency and busy-length checks.
module tb_seq_div;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    longint       due;
    int           busy_n;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     tests = 0;
  int     errors = 0;
  int     busy_run = 0;
  exp_t   sb[$];

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed 64-bit division truncates toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint la;
    longint lb;
    la    = longint'($signed(a));
    lb    = longint'($signed(b));
    e.a   = a;
    e.b   = b;
    e.due = 0;
    if (b == '0) begin
      e.q      = '1;
      e.r      = a;
      e.dbz    = 1'b1;
      e.busy_n = 1;
    end else begin
      e.q      = W'(la / lb);
      e.r      = W'(la % lb);
      e.dbz    = 1'b0;
      e.busy_n = W + 1;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    wait_idle();
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    if (push) begin
      e     = model(a, b);
      e.due = cyc + ((b == '0) ? 2 : W + 2);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = W'(1) << (W - 1);
      2:       v = '1;
      3:       v = W'($urandom_range(1, 20));
      4:       v = W'(-$urandom_range(1, 20));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents done.
  always @(negedge clk) begin
    exp_t   e;
    longint abs_r;
    longint abs_b;
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy && bus.done) chk("busy_and_done", 64'd1, 64'd0);
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", 64'(bus.Q), 64'(e.q));
          chk("remainder", 64'(bus.R), 64'(e.r));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          chk("done_latency", 64'(cyc), 64'(e.due));
          chk("busy_cycles", 64'(busy_run), 64'(e.busy_n));
          if (!e.dbz) begin
            chk("identity", 64'(W'(bus.Q * e.b + bus.R)), 64'(e.a));
            abs_r = longint'($signed(bus.R));
            abs_b = longint'($signed(e.b));
            if (abs_r < 0) abs_r = -abs_r;
            if (abs_b < 0) abs_b = -abs_b;
            chk("rem_bound", 64'(abs_r < abs_b), 64'd1);
          end
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q", 64'(bus.Q), 64'd0);
    chk("rst_r", 64'(bus.R), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(W'(100), W'(7), 1'b1);
    issue(W'(-100), W'(7), 1'b1);
    issue(W'(100), W'(-7), 1'b1);
    issue(W'(-100), W'(-7), 1'b1);
    issue(W'(-5), W'(0), 1'b1);
    issue(W'(10), W'(3), 1'b1);
    issue(W'(1) << (W - 1), '1, 1'b1);
    issue(W'(1) << (W - 1), W'(1), 1'b1);
    issue({1'b0, {(W-1){1'b1}}}, {1'b0, {(W-1){1'b1}}}, 1'b1);
    issue(W'(3), W'(10), 1'b1);

    // Start pulses mid-CALC and in the done cycle must both be dropped.
    issue(W'(1000), W'(3), 1'b1);
    repeat (5) @(negedge clk);
    bus.A     = W'(5);
    bus.B     = W'(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 64'(bus.done), 64'd1);
    bus.A     = W'(9);
    bus.B     = W'(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_cycle_start_ignored", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divide discards it.
    issue(W'(12345), W'(67), 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_q", 64'(bus.Q), 64'd0);
    chk("midrst_r", 64'(bus.R), 64'd0);
    chk("midrst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(W'(12345), W'(67), 1'b1);

    for (int i = 0; i < 1000; i++) begin
      issue(rnd_op(), rnd_op(), 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
